// File: rtl/status_reg_pkg.sv
// Shared constants and address-map helpers for the status register bank.
package status_reg_pkg;

  localparam int DATA_W     = 32;
  localparam int SNAP_CNT_W = 16;
  localparam int DEF_N_REGS = 19;
  localparam int DEF_N_ERR  = 13;

  function automatic int sticky_ofs(input int n_regs);
    return n_regs;
  endfunction

  function automatic int mask_ofs(input int n_regs);
    return n_regs + 1;
  endfunction

  function automatic int cnt_ofs(input int n_regs);
    return n_regs + 2;
  endfunction

endpackage

// File: rtl/status_reg_bank_err_edge_counter.sv
// One hard-error channel: rising-edge detect, maskable sticky bit (W1C) and
// a saturating event counter that ignores the mask.
module err_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             err_i,
  input  logic             mask_i,
  input  logic             clr_sticky_i,
  input  logic             clr_cnt_i,
  output logic             sticky_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             prev_q;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  // prev_q resets low so a level already high after reset counts as a rise
  assign rise = err_i & ~prev_q;

  always_comb begin
    sticky_d = sticky_q & ~clr_sticky_i & ~mask_i;
    if (rise && !mask_i) sticky_d = 1'b1;

    cnt_d = cnt_q;
    if (clr_cnt_i)                    cnt_d = rise ? CNT_W'(1) : '0;
    else if (rise && (cnt_q != '1))   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= err_i;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky_o = sticky_q;
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/status_reg_bank.sv
// Coherent snapshot bank for live status words plus sticky/maskable error
// latching and per-error counters, behind a registered read/ack port.
module status_reg_bank
  import status_reg_pkg::*;
#(
  parameter int          N_REGS     = DEF_N_REGS,
  parameter int          N_ERR      = DEF_N_ERR,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] MASK_RESET = 32'h0,
  parameter int          ADDR_W     = $clog2(N_REGS + 2 + N_ERR)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REGS*DATA_W-1:0] live_status,
  input  logic [N_ERR-1:0]         err_in,
  input  logic                     snap_req,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_ack,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [N_ERR-1:0]         err_sticky,
  output logic                     err_any,
  output logic                     snap_valid,
  output logic [SNAP_CNT_W-1:0]    snap_count
);

  localparam logic [ADDR_W-1:0] STICKY_ADDR = ADDR_W'(sticky_ofs(N_REGS));
  localparam logic [ADDR_W-1:0] MASK_ADDR   = ADDR_W'(mask_ofs(N_REGS));
  localparam int                CNT_BASE    = cnt_ofs(N_REGS);

  logic [DATA_W-1:0]           snap_q [N_REGS];
  logic                        snap_valid_q;
  logic [SNAP_CNT_W-1:0]       snap_cnt_q;
  logic [N_ERR-1:0]            mask_q;
  logic [N_ERR-1:0]            sticky;
  logic [N_ERR-1:0][CNT_W-1:0] cnt;
  logic                        err_any_q;
  logic [DATA_W-1:0]           rd_data_q, rd_data_d;
  logic                        rd_ack_q;
  logic                        sticky_wr;
  logic                        unused_wr_data;

  // Upper wr_data bits are only meaningful for some registers
  assign unused_wr_data = ^wr_data;
  assign sticky_wr      = wr_en && (wr_addr == STICKY_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_REGS; k++) snap_q[k] <= '0;
      snap_valid_q <= 1'b0;
      snap_cnt_q   <= '0;
    end else if (snap_req) begin
      for (int k = 0; k < N_REGS; k++) snap_q[k] <= live_status[k*DATA_W +: DATA_W];
      snap_valid_q <= 1'b1;
      snap_cnt_q   <= snap_cnt_q + SNAP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                               mask_q <= MASK_RESET[N_ERR-1:0];
    else if (wr_en && (wr_addr == MASK_ADDR)) mask_q <= wr_data[N_ERR-1:0];
  end

  for (genvar i = 0; i < N_ERR; i++) begin : g_err
    localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(CNT_BASE + i);

    err_edge_counter #(.CNT_W(CNT_W)) u_err (
      .clk          (clk),
      .reset        (reset),
      .err_i        (err_in[i]),
      .mask_i       (mask_q[i]),
      .clr_sticky_i (sticky_wr & wr_data[i]),
      .clr_cnt_i    (wr_en && (wr_addr == CNT_ADDR)),
      .sticky_o     (sticky[i]),
      .cnt_o        (cnt[i])
    );
  end

  // Mux reads current register state, so same-cycle writes/captures are not seen
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < N_REGS; k++)
      if (rd_addr == ADDR_W'(k)) rd_data_d = snap_q[k];
    if (rd_addr == STICKY_ADDR) rd_data_d = DATA_W'(sticky);
    if (rd_addr == MASK_ADDR)   rd_data_d = DATA_W'(mask_q);
    for (int i = 0; i < N_ERR; i++)
      if (rd_addr == ADDR_W'(CNT_BASE + i)) rd_data_d = DATA_W'(cnt[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      err_any_q <= 1'b0;
    end else begin
      rd_ack_q  <= rd_en;
      err_any_q <= |sticky;
      if (rd_en) rd_data_q <= rd_data_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_ack     = rd_ack_q;
  assign err_sticky = sticky;
  assign err_any    = err_any_q;
  assign snap_valid = snap_valid_q;
  assign snap_count = snap_cnt_q;

endmodule

// File: tb/tb_status_reg_bank.sv
// Directed bench for status_reg_bank (N_REGS=19, N_ERR=13, CNT_W=4).
module tb_status_reg_bank;

  localparam int NR = 19;
  localparam int NE = 13;
  localparam int AW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR*32-1:0] live_status;
  logic [NE-1:0]   err_in;
  logic            snap_req;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [31:0]     rd_data;
  logic            rd_ack;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [31:0]     wr_data;
  logic [NE-1:0]   err_sticky;
  logic            err_any;
  logic            snap_valid;
  logic [15:0]     snap_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] d;
  logic        a;

  status_reg_bank #(.N_REGS(NR), .N_ERR(NE), .CNT_W(4), .MASK_RESET(32'h0)) dut (
    .clk(clk), .reset(reset), .live_status(live_status), .err_in(err_in),
    .snap_req(snap_req), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_ack(rd_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err_sticky(err_sticky), .err_any(err_any), .snap_valid(snap_valid),
    .snap_count(snap_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic ack);
    rd_en = 1'b1; rd_addr = addr;
    tick();
    rd_en = 1'b0;
    data = rd_data; ack = rd_ack;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_err(input int i);
    err_in[i] = 1'b1; tick();
    err_in[i] = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; repeat (3) tick(); reset = 1'b0;
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b want 0", rd_ack); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    checks++; if (err_sticky !== '0 || err_any !== 1'b0) begin errors++; $display("FAIL reset_err got %h/%0b want 0/0", err_sticky, err_any); end
    checks++; if (snap_valid !== 1'b0 || snap_count !== 16'h0) begin errors++; $display("FAIL reset_snap got %0b/%0d want 0/0", snap_valid, snap_count); end
  endtask

  task automatic test_snapshot();
    live_status[11*32 +: 32] = 32'hFFFF_FFFF;
    live_status[12*32 +: 32] = 32'h0000_0ABC;
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    live_status[11*32 +: 32] = 32'h5555_5555;
    live_status[12*32 +: 32] = 32'h6666_6666;
    checks++; if (snap_valid !== 1'b1 || snap_count !== 16'd1) begin errors++; $display("FAIL snap_status got %0b/%0d want 1/1", snap_valid, snap_count); end
    do_read(6'd11, d, a);
    checks++; if (a !== 1'b1 || d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL snap_word11 got %0b/%h want 1/ffffffff", a, d); end
    tick();
    checks++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL ack_single got %0b want 0", rd_ack); end
    checks++; if (rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rd_hold got %h want ffffffff", rd_data); end
    do_read(6'd12, d, a);
    checks++; if (a !== 1'b1 || d !== 32'h0000_0ABC) begin errors++; $display("FAIL snap_word12 got %0b/%h want 1/00000abc", a, d); end
  endtask

  task automatic test_back_to_back();
    rd_en = 1'b1; rd_addr = 6'd11; tick();
    checks++; if (rd_ack !== 1'b1 || rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_first got %0b/%h want 1/ffffffff", rd_ack, rd_data); end
    rd_addr = 6'd12; tick(); rd_en = 1'b0;
    checks++; if (rd_ack !== 1'b1 || rd_data !== 32'h0000_0ABC) begin errors++; $display("FAIL b2b_second got %0b/%h want 1/00000abc", rd_ack, rd_data); end
    // Read in the capture cycle sees the bank before capture
    live_status[0 +: 32] = 32'h0000_1234;
    snap_req = 1'b1; rd_en = 1'b1; rd_addr = 6'd0; tick();
    snap_req = 1'b0; rd_en = 1'b0;
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL precapture got %h want 0", rd_data); end
    do_read(6'd0, d, a);
    checks++; if (d !== 32'h0000_1234 || snap_count !== 16'd2) begin errors++; $display("FAIL postcapture got %h/%0d want 1234/2", d, snap_count); end
  endtask

  task automatic test_sticky_counter();
    repeat (3) pulse_err(3);
    checks++; if (err_sticky !== 13'h0008 || err_any !== 1'b1) begin errors++; $display("FAIL sticky3 got %h/%0b want 0008/1", err_sticky, err_any); end
    do_read(6'd24, d, a);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL cnt3 got %0d want 3", d); end
    do_write(6'd19, 32'h8);
    checks++; if (err_sticky !== 13'h0 || err_any !== 1'b1) begin errors++; $display("FAIL w1c got %h/%0b want 0000/1", err_sticky, err_any); end
    tick();
    checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL err_any_clr got %0b want 0", err_any); end
    do_read(6'd24, d, a);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL cnt3_kept got %0d want 3", d); end
  endtask

  task automatic test_mask();
    wr_en = 1'b1; wr_addr = 6'd20; wr_data = 32'h1; rd_en = 1'b1; rd_addr = 6'd20; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rw_collision got %h want 0", rd_data); end
    do_read(6'd20, d, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL mask_rd got %h want 1", d); end
    pulse_err(0);
    checks++; if (err_sticky !== 13'h0 || err_any !== 1'b0) begin errors++; $display("FAIL masked got %h/%0b want 0000/0", err_sticky, err_any); end
    do_read(6'd21, d, a);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL cnt0_masked got %0d want 1", d); end
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 6'd19; wr_data = 32'h20; err_in[5] = 1'b1; tick();
    wr_en = 1'b0; err_in[5] = 1'b0;
    checks++; if (err_sticky !== 13'h0020) begin errors++; $display("FAIL set_wins got %h want 0020", err_sticky); end
    tick();
    wr_en = 1'b1; wr_addr = 6'd26; wr_data = 32'h0; err_in[5] = 1'b1; tick();
    wr_en = 1'b0; err_in[5] = 1'b0; tick();
    do_read(6'd26, d, a);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL clr_rise got %0d want 1", d); end
    do_write(6'd20, 32'h21);
    tick();
    checks++; if (err_sticky !== 13'h0) begin errors++; $display("FAIL mask_clears got %h want 0000", err_sticky); end
  endtask

  task automatic test_saturation();
    repeat (20) pulse_err(2);
    do_read(6'd23, d, a);
    checks++; if (d !== 32'd15) begin errors++; $display("FAIL cnt_sat got %0d want 15", d); end
  endtask

  task automatic test_reset_mid_read();
    do_write(6'd20, 32'h3);
    rd_en = 1'b1; rd_addr = 6'd20; reset = 1'b1; tick();
    rd_en = 1'b0; reset = 1'b0;
    checks++; if (rd_ack !== 1'b0 || rd_data !== 32'h0) begin errors++; $display("FAIL reset_read got %0b/%h want 0/0", rd_ack, rd_data); end
    checks++; if (snap_count !== 16'h0 || snap_valid !== 1'b0 || err_sticky !== '0) begin errors++; $display("FAIL reset_state got %0d/%0b/%h want 0/0/0", snap_count, snap_valid, err_sticky); end
    do_read(6'd20, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mask got %h want 0", d); end
    for (int i = 0; i < NE; i++) begin
      do_read(AW'(21 + i), d, a);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cnt%0d got %0d want 0", i, d); end
    end
  endtask

  task automatic test_snap_wrap();
    snap_req = 1'b1; repeat (65537) tick(); snap_req = 1'b0;
    checks++; if (snap_count !== 16'd1 || snap_valid !== 1'b1) begin errors++; $display("FAIL snap_wrap got %0d/%0b want 1/1", snap_count, snap_valid); end
  endtask

  task automatic test_out_of_range();
    do_write(6'd0, 32'hDEAD_BEEF);
    do_write(6'd34, 32'hFFFF_FFFF);
    do_read(6'd0, d, a);
    checks++; if (d !== 32'h0000_1234) begin errors++; $display("FAIL snap_wr_ignored got %h want 00001234", d); end
    do_read(6'd34, d, a);
    checks++; if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL oob_read got %0b/%h want 1/0", a, d); end
    do_read(6'd63, d, a);
    checks++; if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL oob_top got %0b/%h want 1/0", a, d); end
  endtask

  initial begin
    reset = 1'b1; live_status = '0; err_in = '0; snap_req = 1'b0;
    rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_snapshot();
    test_back_to_back();
    test_sticky_counter();
    test_mask();
    test_collision();
    test_saturation();
    test_reset_mid_read();
    test_snap_wrap();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_reg_bank.md
Name: status_reg_bank

Overview:
Parametrised successor to the Rider's combinational status register block. It captures N_REGS live 32-bit status words into a snapshot bank on request, so multi-word readouts are coherent (for example, trigger timestamp LSB/MSB). It also adds sticky, maskable hard-error latching with write-one-to-clear, and a per-error saturating event counter. It sits between the status sources and the IPbus slave, with a registered read/ack interface.

Parameters:
N_REGS, 19, number of 32-bit live status words captured per snapshot
N_ERR, 13, number of hard-error inputs (max 32)
CNT_W, 16, width of each per-error event counter (max 32)
MASK_RESET, 0, reset value of the error mask (bit=1 masks that error)
ADDR_W, clog2(N_REGS+2+N_ERR), read/write address width

Ports:
clk  in  1  user interface clock
reset  in  1  synchronous, active-high reset
live_status  in  N_REGS*32  live status words, word k at bits [32k+31:32k]
err_in  in  N_ERR  hard-error levels, same clock domain
snap_req  in  1  single-cycle request to capture live_status
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  read address
rd_data  out  32  read data
rd_ack  out  1  read acknowledge
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  32  write data
err_sticky  out  N_ERR  latched, unmasked error bits
err_any  out  1  OR of err_sticky
snap_valid  out  1  at least one snapshot taken since reset
snap_count  out  16  number of snapshots, wraps modulo 2^16

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high. On reset all outputs go to 0, the snapshot bank is cleared, the counters are cleared, err_prev is cleared, and mask = MASK_RESET. Reset mid-read drops a pending rd_ack.
- Address map:
  - 0..N_REGS-1: snapshot words.
  - N_REGS: sticky error register, zero-extended.
  - N_REGS+1: mask register.
  - N_REGS+2+i: counter i, zero-extended.
  - Any higher address: reads 32'h0, writes ignored.
- Snapshot: if snap_req is high in cycle t, the bank equals live_status as sampled at t, visible from t+1. snap_valid is set at t+1 and stays set. snap_count increments at t+1, wrapping 0xFFFF->0. A read issued in cycle t returns pre-capture data.
- Edge detect: err_prev <= err_in each cycle; rise = err_in & ~err_prev. An error already high on the first cycle after reset counts as a rise.
- Sticky: bit i sets on rise[i] & ~mask[i]. A write to N_REGS clears bits where wr_data=1 (W1C). If a set and a clear hit the same bit in the same cycle, the set wins. Writing a mask bit to 1 also clears that sticky bit the next cycle. err_any is registered: the OR of err_sticky, one cycle later.
- Counters: counter i increments on rise[i] regardless of mask and saturates at 2^CNT_W-1. Any write to N_REGS+2+i clears counter i. If a clear and a rise hit the same cycle, the counter becomes 1.
- Mask: a write to N_REGS+1 loads wr_data[N_ERR-1:0].
- Writes to snapshot addresses are ignored.
- Read: rd_en at t gives rd_ack=1 for exactly one cycle at t+1, with rd_data registered. rd_data holds until the next read. Back-to-back rd_en gives an ack every cycle.
- Read/write collision: a read and a write to the same address in the same cycle return the pre-write value.

Decomposition:
- Package status_reg_pkg holds:
  - DATA_W=32;
  - the address offset functions (STICKY_OFS=N_REGS, MASK_OFS=N_REGS+1, CNT_OFS=N_REGS+2);
  - the default N_REGS and N_ERR values;
  - the SNAP_CNT_W=16 constant.
- Sub-module err_edge_counter: edge detect plus saturating counter plus sticky bit for one error. It is instantiated N_ERR times via generate.

Test Plan:
1. Drive live_status word 11 = 32'hFFFF_FFFF and word 12 = 32'h0000_0ABC, pulse snap_req, change both words, then read addresses 11 and 12 -> 32'hFFFF_FFFF and 32'h0000_0ABC, each with rd_ack one cycle after rd_en; snap_count=1, snap_valid=1.
2. Pulse err_in[3] three times with mask=0 -> err_sticky[3]=1, err_any=1, read of N_REGS+2+3 returns 3. Then write 32'h8 to N_REGS -> sticky clears, counter stays 3.
3. Write mask=32'h1, then pulse err_in[0] -> err_sticky[0]=0, err_any=0, counter 0 = 1.
4. Hold a W1C write to bit 5 in the same cycle as a rise on err_in[5] -> err_sticky[5]=1. Clear counter 5 in the same cycle as a rise -> counter 5 = 1.
5. With CNT_W=4, drive 20 rises on err_in[2] -> counter 2 saturates at 15. Pulse snap_req 65537 times -> snap_count=1.
6. Assert reset mid-read with mask written to 0x3 -> rd_ack=0, all counters 0, mask=MASK_RESET. Read of address N_REGS+2+N_ERR returns 0 with ack.
